cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, data width; TAG_W, 3, tag width; IDX_W, 3, index width, fixed at 3 to match the 8-entry data array.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  CPU request; held with operands until cpu_ready.
REQ-005 cpu_wr  input  1  1 = write, 0 = read.
REQ-006 cpu_addr  input  6  {tag[5:3], index[2:0]}.
REQ-007 cpu_wdata  input  8  write data.
REQ-008 cpu_rdata  output  8  read data, registered.
REQ-009 cpu_ready  output  1  one-cycle completion pulse.
REQ-010 flush  input  1  invalidate all lines.
REQ-011 cm_addr  output  3  data-array index; cm_rd output 1; cm_wr output 1; cm_wdata output 8; cm_rdata input 8. cm_rdata is valid one cycle after cm_rd.
REQ-012 mem_req  output  1  main-memory request; mem_wr output 1; mem_addr output 6; mem_wdata output 8; mem_rdata input 8; mem_ack input 1.
REQ-013 hit_cnt, miss_cnt  outputs  8 each  saturating statistics.

Function
REQ-014 States SHALL be IDLE, LOOKUP, RD_HIT, MEM_RD, FILL, MEM_WR and DONE, with Moore outputs.
REQ-015 Acceptance, IDLE only: cpu_req=1 latches addr, wr and wdata, then goes to LOOKUP; cpu_req is ignored in all other states.
REQ-016 Flush, IDLE only: flush=1 clears all 8 valid bits at the edge and stays in IDLE; flush has priority over cpu_req, so a simultaneous request is accepted the following cycle.
REQ-017 LOOKUP: hit = valid[idx] && tag[idx]==addr tag; hit_cnt or miss_cnt increments, saturating at 255.
REQ-018 Read hit: cm_rd=1 in LOOKUP, then RD_HIT, where cpu_rdata<=cm_rdata, then DONE; cpu_ready is high in the 3rd cycle after the accepting edge.
REQ-019 Read miss: LOOKUP goes to MEM_RD, which drives mem_req=1, mem_wr=0, mem_addr=addr. This holds until mem_ack is sampled high. At that edge mem_rdata goes into a fill register and the state goes to FILL.
REQ-020 FILL: cm_wr=1, cm_addr=idx, cm_wdata=fill; valid[idx]<=1; tag[idx]<=tag; cpu_rdata<=fill; then DONE.
REQ-021 Write (write-through, no-write-allocate): on a hit, LOOKUP drives cm_wr=1 with cpu_wdata. Both hit and miss then go to MEM_WR: mem_req=1, mem_wr=1, mem_addr, mem_wdata held until mem_ack, then DONE. A write miss leaves tag/valid unchanged.
REQ-022 DONE: cpu_ready=1 for exactly one cycle, then IDLE; no request is accepted during DONE.
REQ-023 mem_ack may arrive in the first MEM_RD/MEM_WR cycle; mem_ack outside these states is ignored.
REQ-024 cm_rd and cm_wr SHALL never both be high; mem outputs are 0 when mem_req=0.
REQ-025 cpu_rdata SHALL hold its last value except in RD_HIT and FILL.

Reset
REQ-026 rst=1 at an edge SHALL force: IDLE; valid[7:0]=0; tags=0; cpu_rdata=0; counters=0; fill=0.
REQ-027 Reset mid-operation SHALL abort the request, with mem_req, cm_* and cpu_ready low from the next cycle; the data array shares rst.

Structure
REQ-028 State encodings and width constants SHALL live in a shared include file used by cache_ctrl and the system top.
REQ-029 The tag/valid store SHALL be the sub-module cache_tag_array: 8x(1+3) registers with flush-clear and a combinational hit output.
REQ-030 cache_ctrl SHALL not instantiate the data array; the top wires the cm_* ports to it.

Verification
REQ-031 Reset; read 0x0D; memory acks after 2 cycles with 0xA5 -> mem_addr=0x0D, cm_wr at idx 5 with 0xA5, cpu_rdata=0xA5, miss_cnt=1.
REQ-032 Read 0x0D again -> no mem_req, cpu_ready in the 3rd cycle after acceptance, cpu_rdata=0xA5, hit_cnt=1.
REQ-033 Write 0x0D=0x3C -> cm_wr in LOOKUP, memory write (0x0D, 0x3C); a subsequent read hits and returns 0x3C.
REQ-034 Read 0x2D (conflict at idx 5) -> miss and refill; then read 0x0D -> miss; miss_cnt increments each time.
REQ-035 Write miss to 0x07 -> memory write only, no cm_wr; a following read of 0x07 misses.
REQ-036 flush and cpu_req together -> flush wins, request accepted next cycle and misses; rst during MEM_RD -> mem_req low next cycle, state IDLE, counters 0.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared widths, FSM state encoding and saturating-counter helper for the cache controller.
// No logic, so it adds no latency and applies no backpressure.
package cache_ctrl_pkg;

  localparam int CC_DATA_W = 8;
  localparam int CC_TAG_W  = 3;
  localparam int CC_IDX_W  = 3;
  localparam int CC_LINES  = 1 << CC_IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RD_HIT,
    S_MEM_RD,
    S_FILL,
    S_MEM_WR,
    S_DONE
  } cc_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Per-line valid+tag registers with flush-clear; zero-latency combinational hit, update lands at the edge.
// Flush and update are never requested together, so flush simply wins; no backpressure.
module cache_tag_array
  import cache_ctrl_pkg::*;
#(
  parameter int TAG_W = CC_TAG_W,
  parameter int IDX_W = CC_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_en) begin
      valid_d[upd_idx] = 1'b1;
      tag_d[upd_idx]   = upd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller; read hit completes 3 cycles after acceptance.
// One request at a time: cpu_req is only sampled in IDLE, memory stalls are held until mem_ack.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int DATA_W = CC_DATA_W,
  parameter int TAG_W  = CC_TAG_W,
  parameter int IDX_W  = CC_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_wr,
  input  logic [TAG_W+IDX_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ready,
  input  logic                   flush,
  output logic [IDX_W-1:0]       cm_addr,
  output logic                   cm_rd,
  output logic                   cm_wr,
  output logic [DATA_W-1:0]      cm_wdata,
  input  logic [DATA_W-1:0]      cm_rdata,
  output logic                   mem_req,
  output logic                   mem_wr,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ack,
  output logic [7:0]             hit_cnt,
  output logic [7:0]             miss_cnt
);

  localparam int ADDR_W = TAG_W + IDX_W;

  cc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        hit_cnt_q, hit_cnt_d;
  logic [7:0]        miss_cnt_q, miss_cnt_d;

  logic              tag_flush, tag_upd, hit;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  cache_tag_array #(
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_tags (
    .clk     (clk),
    .rst     (rst),
    .flush   (tag_flush),
    .upd_en  (tag_upd),
    .upd_idx (idx),
    .upd_tag (tag),
    .lk_idx  (idx),
    .lk_tag  (tag),
    .hit     (hit)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    fill_d     = fill_q;
    rdata_d    = rdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    cm_addr    = '0;
    cm_rd      = 1'b0;
    cm_wr      = 1'b0;
    cm_wdata   = '0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_ready  = 1'b0;
    tag_flush  = 1'b0;
    tag_upd    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A request coinciding with flush stays pending and is taken next cycle.
        if (flush) begin
          tag_flush = 1'b1;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          wr_d    = cpu_wr;
          wdata_d = cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cm_addr = idx;
        if (hit) hit_cnt_d = sat_inc(hit_cnt_q);
        else     miss_cnt_d = sat_inc(miss_cnt_q);
        if (wr_q) begin
          if (hit) begin
            cm_wr    = 1'b1;
            cm_wdata = wdata_q;
          end
          state_d = S_MEM_WR;
        end else if (hit) begin
          cm_rd   = 1'b1;
          state_d = S_RD_HIT;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_RD_HIT: begin
        rdata_d = cm_rdata;
        state_d = S_DONE;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        cm_wr    = 1'b1;
        cm_addr  = idx;
        cm_wdata = fill_q;
        tag_upd  = 1'b1;
        rdata_d  = fill_q;
        state_d  = S_DONE;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      fill_q     <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      fill_q     <= fill_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
